// File: rtl/fp_posit_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fp_posit_pkg
//  Description : Shared constants and types for the FP16 x posit(es=0)
//                multiplier front end of the FP-Posit MAC.
//                - FP16 field widths and exponent bias
//                - legal posit width range (MIN_N..MAX_N)
//                - product significand format (2.12)
//                - prod_t bundle {sign, exp, man}
//                - clamp_n() maps a requested precision into range
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_posit_pkg;

  localparam int ACT_W     = 16;         // IEEE binary16 width
  localparam int EXP_W     = 5;          // FP16 exponent field width
  localparam int MAN_W     = 10;         // FP16 fraction field width
  localparam int BIAS      = 15;         // FP16 exponent bias
  localparam int EXP_SAT   = 2 * BIAS;   // largest finite biased exponent

  localparam int MAX_N     = 8;          // widest posit weight
  localparam int MIN_N     = 3;          // narrowest posit weight

  localparam int PROD_W    = MAN_W + 4;  // 11b x 3b significand product
  localparam int PROD_FRAC = 12;         // fraction bits of the 2.12 format
  localparam logic [PROD_W-1:0] PROD_ONE = PROD_W'(1) << PROD_FRAC;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [PROD_W-1:0] man;
  } prod_t;

  function automatic logic [3:0] clamp_n(input logic [3:0] p);
    if (p < 4'(MIN_N)) return 4'(MIN_N);
    if (p > 4'(MAX_N)) return 4'(MAX_N);
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/posit_decode.sv
`default_nettype none
// ============================================================================
//  Module      : posit_decode
//  Description : Combinational decode of an n-bit posit (es=0) held in the
//                low n bits of 'word'.
//  Ports       : word [7:0] in  - posit word, right aligned
//                n    [3:0] in  - posit width, already clamped to 3..8
//                s          out - sign bit
//                k    [3:0] out - signed regime value
//                frac [1:0] out - top two fraction bits, zero filled
//                zero       out - word is zero or NaR (all bits below sign 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_decode
  import fp_posit_pkg::*;
(
  input  logic [MAX_N-1:0]  word,
  input  logic [3:0]        n,
  output logic              s,
  output logic signed [3:0] k,
  output logic [1:0]        frac,
  output logic              zero
);

  logic [MAX_N-1:0] mask;
  logic [MAX_N-1:0] body;
  logic [MAX_N-1:0] mag;
  logic [MAX_N-1:0] t;
  logic [MAX_N-1:0] f;
  logic [3:0]       len;
  logic [3:0]       run;
  logic [3:0]       used;
  logic             stop;

  always_comb begin
    mask = MAX_N'((9'd1 << n) - 9'd1);
    body = word & mask;
    // sign is the top bit of the n-bit field
    s    = |(body & ~(mask >> 1));
    zero = ((body & (mask >> 1)) == '0);
    mag  = s ? ((~body + MAX_N'(1)) & mask) : body;

    // left-justify the bits after the sign so the regime starts at the MSB;
    // vacated low bits are zero, which gives the zero-filled fraction for free
    t   = mag << (4'd9 - n);
    len = n - 4'd1;

    run  = '0;
    stop = 1'b0;
    for (int i = 0; i < MAX_N - 1; i++) begin
      if (!stop && (4'(i) < len) && (t[MAX_N-1-i] == t[MAX_N-1]))
        run = run + 4'd1;
      else
        stop = 1'b1;
    end

    // skip the terminating bit only when the run ended before the word did
    used = (run < len) ? run + 4'd1 : run;
    f    = t << used;
    frac = f[MAX_N-1 -: 2];
    k    = t[MAX_N-1] ? $signed(run - 4'd1) : $signed(4'd0 - run);
  end

endmodule
`default_nettype wire

// File: rtl/fp_posit_mul.sv
`default_nettype none
// ============================================================================
//  Module      : fp_posit_mul
//  Description : FP16 activation x serial posit(es=0) weight multiplier.
//                Weight bits arrive MSB first, one per valid cycle; the
//                unnormalised product is registered one cycle after the last
//                weight bit.
//  Ports       : clk, rst (async active-low)
//                act[15:0]   FP16 activation, latched with the weight sign bit
//                w, valid    serial weight bit and its qualifier
//                set, precision[3:0]  latch posit width (clamped 3..8)
//                sign_out, exp_out[4:0], man_out[13:0]  product (2.12 format)
//                start_acc   first result of a valid burst
//                done        new result on the outputs this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_posit_mul
  import fp_posit_pkg::*;
#(
  parameter int ACT_WIDTH = ACT_W,
  parameter int EXP_WIDTH = EXP_W,
  parameter int MAN_WIDTH = MAN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ACT_WIDTH-1:0]   act,
  input  logic                   w,
  input  logic                   valid,
  input  logic                   set,
  input  logic [3:0]             precision,
  output logic                   sign_out,
  output logic [EXP_WIDTH-1:0]   exp_out,
  output logic [MAN_WIDTH+3:0]   man_out,
  output logic                   start_acc,
  output logic                   done
);

  logic [3:0]                  n_reg;
  logic [3:0]                  cnt;
  logic [MAX_N-2:0]            sr;
  logic [MAX_N-1:0]            word;
  logic [ACT_WIDTH-1:0]        act_q;
  logic                        in_burst;
  logic                        last;

  logic                        w_s;
  logic signed [3:0]           w_k;
  logic [1:0]                  w_frac;
  logic                        w_zero;

  logic [EXP_WIDTH-1:0]        e_act;
  logic [MAN_WIDTH:0]          sig_act;
  logic [MAN_WIDTH+3:0]        man_prod;
  logic signed [EXP_WIDTH+1:0] e_sum;
  prod_t                       res;
  prod_t                       out_q;

  // word as it will look once the current bit is shifted in
  assign word = {sr, w};
  assign last = valid && (cnt == n_reg - 4'd1);

  posit_decode u_decode (
    .word (word),
    .n    (n_reg),
    .s    (w_s),
    .k    (w_k),
    .frac (w_frac),
    .zero (w_zero)
  );

  assign e_act    = act_q[ACT_WIDTH-2 -: EXP_WIDTH];
  assign sig_act  = {1'b1, act_q[MAN_WIDTH-1:0]};
  assign man_prod = (MAN_WIDTH+4)'(sig_act) * (MAN_WIDTH+4)'({1'b1, w_frac});
  assign e_sum    = $signed({2'b00, e_act}) + (EXP_WIDTH+2)'(w_k);

  always_comb begin
    res.sign = act_q[ACT_WIDTH-1] ^ w_s;
    res.exp  = e_sum[EXP_WIDTH-1:0];
    res.man  = man_prod;
    if (w_zero || (e_act == '0)) begin
      // zero/NaR weight, or zero/subnormal activation (flushed)
      res = '0;
    end else if (e_act == '1) begin
      // Inf/NaN activation propagates as max exponent with unit significand
      res.exp = '1;
      res.man = PROD_ONE;
    end else if (e_sum < (EXP_WIDTH+2)'(1)) begin
      res.exp = '0;
      res.man = '0;
    end else if (e_sum > (EXP_WIDTH+2)'(EXP_SAT)) begin
      res.exp = EXP_WIDTH'(EXP_SAT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_reg     <= 4'd4;
      cnt       <= '0;
      sr        <= '0;
      act_q     <= '0;
      in_burst  <= 1'b0;
      out_q     <= '0;
      done      <= 1'b0;
      start_acc <= 1'b0;
    end else begin
      done      <= 1'b0;
      start_acc <= 1'b0;
      if (set) begin
        n_reg    <= clamp_n(precision);
        cnt      <= '0;
        in_burst <= 1'b0;
      end else if (valid) begin
        sr <= word[MAX_N-2:0];
        if (cnt == '0) act_q <= act;
        if (last) begin
          cnt       <= '0;
          out_q     <= res;
          done      <= 1'b1;
          start_acc <= !in_burst;
          in_burst  <= 1'b1;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        // any idle cycle ends the burst
        in_burst <= 1'b0;
      end
    end
  end

  assign sign_out = out_q.sign;
  assign exp_out  = out_q.exp;
  assign man_out  = out_q.man;

endmodule
`default_nettype wire

// File: tb/tb_fp_posit_mul.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_posit_mul
//  Description : Self-checking bench for fp_posit_mul. A behavioural posit
//                model predicts every result and its due cycle; a negedge
//                monitor compares outputs on every cycle. Literal vectors pin
//                both the model and the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_posit_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w = 1'b0;
  logic        valid = 1'b0;
  logic        set = 1'b0;
  logic [15:0] act = '0;
  logic [3:0]  precision = '0;
  logic        sign_out;
  logic [4:0]  exp_out;
  logic [13:0] man_out;
  logic        start_acc;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_model = 4;
  bit burst   = 1'b0;

  typedef struct {
    int          due;
    logic        start;
    logic [19:0] res;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_cur;
  logic [20:0] done_log[$];
  logic [19:0] exp_last = '0;

  fp_posit_mul dut (
    .clk       (clk),
    .rst       (rst),
    .act       (act),
    .w         (w),
    .valid     (valid),
    .set       (set),
    .precision (precision),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .man_out   (man_out),
    .start_acc (start_acc),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Posit(es=0) x FP16 reference: decode by walking the bits of the value.
  function automatic logic [19:0] model(input int n, input logic [7:0] wbits,
                                        input logic [15:0] a);
    int v, s, first, run, pos, f2, k, e, sum, man, sgn;
    v = int'(wbits) & ((1 << n) - 1);
    s = (v >> (n - 1)) & 1;
    if (((v & ((1 << (n - 1)) - 1)) == 0) || (a[14:10] == 5'd0)) return '0;
    if (s != 0) v = ((1 << n) - v) & ((1 << n) - 1);
    pos   = n - 2;
    first = (v >> pos) & 1;
    run   = 0;
    while (pos >= 0 && (((v >> pos) & 1) == first)) begin
      run++;
      pos--;
    end
    pos--;
    f2 = 0;
    for (int j = 0; j < 2; j++) begin
      f2 = f2 * 2;
      if (pos >= 0) begin
        f2 = f2 + ((v >> pos) & 1);
        pos--;
      end
    end
    k   = (first != 0) ? run - 1 : -run;
    sgn = int'(a[15]) ^ s;
    e   = int'(a[14:10]);
    if (e == 31) return {sgn[0], 5'd31, 14'h1000};
    sum = e + k;
    man = (1024 + int'(a[9:0])) * (4 + f2);
    if (sum < 1) return {sgn[0], 5'd0, 14'd0};
    if (sum > 30) sum = 30;
    return {sgn[0], sum[4:0], man[13:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs", 32'({done, start_acc, sign_out, exp_out, man_out}), 32'd0);
      exp_q.delete();
      exp_last = '0;
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e_cur = exp_q.pop_front();
      chk("done_pulse", 32'(done), 32'd1);
      chk("start_acc", 32'(start_acc), 32'(e_cur.start));
      chk("product", 32'({sign_out, exp_out, man_out}), 32'(e_cur.res));
      exp_last = e_cur.res;
      done_log.push_back({start_acc, sign_out, exp_out, man_out});
    end else begin
      chk("idle_pulses", 32'({done, start_acc}), 32'd0);
      chk("hold", 32'({sign_out, exp_out, man_out}), 32'(exp_last));
    end
  end

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk); #1;
      valid = 1'b0;
      set   = 1'b0;
      w     = 1'($urandom);
      act   = 16'($urandom);
      burst = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] bits, input logic [15:0] a,
                      input int gap_after = 0, input int gap_len = 0);
    logic [19:0] r;
    for (int i = n_model - 1; i >= 0; i--) begin
      @(posedge clk); #1;
      valid = 1'b1;
      set   = 1'b0;
      w     = bits[i];
      act   = (i == n_model - 1) ? a : 16'($urandom);
      if (i == 0) begin
        r = model(n_model, bits, a);
        exp_q.push_back('{due: cyc + 1, start: !burst, res: r});
        burst = 1'b1;
      end
      if (gap_len > 0 && (n_model - i) == gap_after) idle(gap_len);
    end
  endtask

  task automatic partial(input logic [7:0] bits, input int nb);
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      valid = 1'b1;
      set   = 1'b0;
      w     = bits[n_model - 1 - i];
      act   = 16'($urandom);
    end
  endtask

  task automatic set_prec(input logic [3:0] p);
    @(posedge clk); #1;
    set       = 1'b1;
    valid     = 1'b0;
    precision = p;
    n_model   = (p < 3) ? 3 : ((p > 8) ? 8 : int'(p));
    burst     = 1'b0;
    @(posedge clk); #1;
    set = 1'b0;
  endtask

  task automatic chk_log(input string name, input logic start, input logic [19:0] res);
    logic [20:0] got;
    if (done_log.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no result seen, expected %h", name, {start, res});
    end else begin
      got = done_log.pop_front();
      chk(name, 32'(got), 32'({start, res}));
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // model pinned against hand-computed values
    chk("model_unity", 32'(model(4, 8'b0100, 16'h3C00)), 32'({1'b0, 5'd15, 14'h1000}));
    chk("model_frac",  32'(model(4, 8'b0101, 16'h3C00)), 32'({1'b0, 5'd15, 14'h1800}));
    chk("model_neg",   32'(model(4, 8'b1100, 16'h1234)), 32'({1'b1, 5'd4,  14'h18D0}));
    chk("model_n8",    32'(model(8, 8'b01001101, 16'h3C00)), 32'({1'b0, 5'd15, 14'h1400}));

    idle(2);
    done_log.delete();
    send(8'b0100, 16'h3C00);
    idle(2);
    chk_log("t1_unity", 1'b1, {1'b0, 5'd15, 14'h1000});

    send(8'b0110, 16'h3C00);
    send(8'b0101, 16'h3C00);
    idle(2);
    chk_log("t2_k1",   1'b1, {1'b0, 5'd16, 14'h1000});
    chk_log("t2_frac", 1'b0, {1'b0, 5'd15, 14'h1800});

    send(8'b1100, 16'h1234);
    idle(2);
    chk_log("t3_neg", 1'b1, {1'b1, 5'd4, 14'h18D0});

    send(8'b0000, 16'h3C00);
    send(8'b1000, 16'hBC00);
    send(8'b0100, 16'h0001);
    idle(2);
    chk_log("t4_wzero",   1'b1, 20'd0);
    chk_log("t4_nar",     1'b0, 20'd0);
    chk_log("t4_subnorm", 1'b0, 20'd0);

    send(8'b0100, 16'hFC00);
    send(8'b0001, 16'h8400);
    send(8'b0010, 16'h0800);
    idle(2);
    chk_log("t4_inf",       1'b1, {1'b1, 5'd31, 14'h1000});
    chk_log("t4_underflow", 1'b0, {1'b1, 5'd0,  14'd0});
    chk_log("t4_exp_min",   1'b0, {1'b0, 5'd1,  14'h1000});

    partial(8'b0110, 2);
    @(posedge clk); #1;
    rst     = 1'b0;
    valid   = 1'b0;
    burst   = 1'b0;
    n_model = 4;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(3);
    chk("t5_no_done", 32'(done_log.size()), 32'd0);
    send(8'b0100, 16'h3C00);
    idle(2);
    chk_log("t5_after_reset", 1'b1, {1'b0, 5'd15, 14'h1000});

    set_prec(4'd8);
    send(8'b01111111, 16'h7800);
    send(8'b00000001, 16'h3C00);
    send(8'b01001101, 16'h3C00);
    idle(2);
    chk_log("t6_saturate", 1'b1, {1'b0, 5'd30, 14'h1000});
    chk_log("t6_kmin",     1'b0, {1'b0, 5'd9,  14'h1000});
    chk_log("t6_trunc",    1'b0, {1'b0, 5'd15, 14'h1400});

    set_prec(4'd2);
    send(8'b011, 16'h3C00);
    idle(2);
    chk_log("t7_clamp_lo", 1'b1, {1'b0, 5'd16, 14'h1000});
    set_prec(4'd15);
    send(8'b01001101, 16'h3C00);
    idle(2);
    chk_log("t7_clamp_hi", 1'b1, {1'b0, 5'd15, 14'h1400});

    set_prec(4'd4);
    partial(8'b0110, 2);
    set_prec(4'd4);
    send(8'b0100, 16'h3C00);
    idle(2);
    chk_log("t7_set_discard", 1'b1, {1'b0, 5'd15, 14'h1000});

    send(8'b0101, 16'h3C00, 2, 3);
    idle(2);
    chk_log("t8_gap", 1'b1, {1'b0, 5'd15, 14'h1800});

    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
